// File: rtl/insert_sort_stream.sv
// Streaming, stable insertion sorter: one value per accepted handshake is inserted
// into a register array that stays sorted; results are presented in parallel.
module insert_sort_stream #(
    parameter int unsigned INPUTVALS      = 64,
    parameter int unsigned INPUTBITWIDTHS = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              sortstart,
    input  logic                              descending,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [INPUTBITWIDTHS-1:0]         in_data,
    input  logic                              in_last,
    output logic                              sortdone,
    output logic [INPUTBITWIDTHS-1:0]         sorted [INPUTVALS],
    output logic [$clog2(INPUTVALS):0]        sorted_positions [INPUTVALS],
    output logic [$clog2(INPUTVALS):0]        sorted_count,
    output logic                              error
);
    localparam int unsigned PW = $clog2(INPUTVALS) + 1;

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                    r_state;
    logic                      r_desc;
    logic                      r_ready;
    logic                      r_done;
    logic                      r_err;
    logic [PW-1:0]             r_count;
    logic [INPUTBITWIDTHS-1:0] r_val [INPUTVALS];
    logic [PW-1:0]             r_pos [INPUTVALS];

    logic [INPUTVALS-1:0]      w_ins;
    logic [INPUTVALS-1:0]      w_new;
    logic                      w_accept;
    logic                      w_final;

    // w_ins marks every slot at or after the insert point: an empty slot, or an
    // occupied one that strictly loses to in_data (ties keep arrival order).
    always_comb begin
        w_ins = '0;
        for (int unsigned k = 0; k < INPUTVALS; k++) begin
            if (PW'(k) >= r_count)
                w_ins[k] = 1'b1;
            else if (r_desc)
                w_ins[k] = (r_val[k] < in_data);
            else
                w_ins[k] = (r_val[k] > in_data);
        end
        w_new = w_ins & ~{w_ins[INPUTVALS-2:0], 1'b0};
    end

    assign w_accept = in_valid & r_ready;
    assign w_final  = in_last | (r_count == PW'(INPUTVALS - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_desc  <= 1'b0;
            r_ready <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_count <= '0;
            for (int unsigned k = 0; k < INPUTVALS; k++) begin
                r_val[k] <= '0;
                r_pos[k] <= PW'(INPUTVALS);
            end
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    if (in_valid)
                        r_err <= 1'b1;
                    if (sortstart) begin
                        r_state <= LOAD;
                        r_ready <= 1'b1;
                        r_desc  <= descending;
                        r_count <= '0;
                        for (int unsigned k = 0; k < INPUTVALS; k++) begin
                            r_val[k] <= '0;
                            r_pos[k] <= PW'(INPUTVALS);
                        end
                    end
                end
                LOAD: begin
                    if (sortstart)
                        r_err <= 1'b1;
                    if (w_accept) begin
                        if (w_new[0]) begin
                            r_val[0] <= in_data;
                            r_pos[0] <= r_count;
                        end
                        // Slots past the insert point shift up by one toward higher index.
                        for (int unsigned k = 1; k < INPUTVALS; k++) begin
                            if (w_new[k]) begin
                                r_val[k] <= in_data;
                                r_pos[k] <= r_count;
                            end else if (w_ins[k]) begin
                                r_val[k] <= r_val[k-1];
                                r_pos[k] <= r_pos[k-1];
                            end
                        end
                        r_count <= r_count + 1'b1;
                        if (w_final) begin
                            r_state <= DONE;
                            r_ready <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = r_ready;
    assign sortdone         = r_done;
    assign error            = r_err;
    assign sorted_count     = r_count;
    assign sorted           = r_val;
    assign sorted_positions = r_pos;

endmodule

// File: tb/tb_insert_sort_stream.sv
// Bench for insert_sort_stream: directed vector table, hand-written corner
// sequences, and random batches checked against a rank-based reference model.
module tb_insert_sort_stream;
    localparam int N  = 8;
    localparam int W  = 8;
    localparam int PW = 4;

    typedef logic [N-1:0][W-1:0]  vals_t;
    typedef logic [N-1:0][PW-1:0] poss_t;

    typedef struct {
        string name;
        logic  desc;
        int    n;
        vals_t data;
        logic  use_last;
        vals_t ev;
        poss_t ep;
        int    ecnt;
    } vec_t;

    logic          clk;
    logic          reset;
    logic          sortstart;
    logic          descending;
    logic          in_valid;
    logic          in_ready;
    logic [W-1:0]  in_data;
    logic          in_last;
    logic          sortdone;
    logic [W-1:0]  sorted [N];
    logic [PW-1:0] sorted_positions [N];
    logic [PW-1:0] sorted_count;
    logic          error;

    int checks = 0;
    int errors = 0;

    insert_sort_stream #(.INPUTVALS(N), .INPUTBITWIDTHS(W)) dut (
        .clk(clk), .reset(reset), .sortstart(sortstart), .descending(descending),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .sortdone(sortdone), .sorted(sorted), .sorted_positions(sorted_positions),
        .sorted_count(sorted_count), .error(error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic vals_t mkv(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
        vals_t v;
        v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3);
        v[4] = W'(a4); v[5] = W'(a5); v[6] = W'(a6); v[7] = W'(a7);
        return v;
    endfunction

    function automatic poss_t mkp(int a0, int a1, int a2, int a3, int a4, int a5, int a6, int a7);
        poss_t p;
        p[0] = PW'(a0); p[1] = PW'(a1); p[2] = PW'(a2); p[3] = PW'(a3);
        p[4] = PW'(a4); p[5] = PW'(a5); p[6] = PW'(a6); p[7] = PW'(a7);
        return p;
    endfunction

    // Reference: each value's final slot is its rank among the batch under a
    // stable ordering (earlier arrival wins ties).
    task automatic model(input logic desc, input int n, input vals_t d,
                         output vals_t ev, output poss_t ep);
        for (int k = 0; k < N; k++) begin
            ev[k] = '0;
            ep[k] = PW'(N);
        end
        for (int i = 0; i < n; i++) begin
            int rank = 0;
            for (int j = 0; j < n; j++) begin
                if (desc ? (d[j] > d[i]) : (d[j] < d[i])) rank++;
                else if (d[j] == d[i] && j < i) rank++;
            end
            ev[rank] = d[i];
            ep[rank] = PW'(i);
        end
    endtask

    task automatic check_outputs(input string nm, input vals_t ev, input poss_t ep, input int ecnt);
        chk($sformatf("%s count", nm), 32'(sorted_count), 32'(ecnt));
        for (int k = 0; k < N; k++) begin
            chk($sformatf("%s val[%0d]", nm, k), 32'(sorted[k]), 32'(ev[k]));
            chk($sformatf("%s pos[%0d]", nm, k), 32'(sorted_positions[k]), 32'(ep[k]));
        end
    endtask

    task automatic start_batch(input string nm, input logic desc);
        sortstart  = 1'b1;
        descending = desc;
        in_valid   = 1'b0;
        step();
        sortstart  = 1'b0;
        descending = 1'($urandom);
        chk($sformatf("%s ready after start", nm), 32'(in_ready), 32'd1);
        chk($sformatf("%s count after start", nm), 32'(sorted_count), 32'd0);
    endtask

    // gap_mode: 0 back-to-back, 1 one idle beat between values, 2 random idle beats
    task automatic run_batch(input string nm, input logic desc, input int n, input vals_t data,
                             input logic use_last, input int gap_mode,
                             input vals_t ev, input poss_t ep, input int ecnt);
        start_batch(nm, desc);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_data  = data[i];
            in_last  = use_last && (i == n - 1);
            step();
            in_valid = 1'b0;
            chk($sformatf("%s done@%0d", nm, i), 32'(sortdone), 32'(i == n - 1));
            chk($sformatf("%s ready@%0d", nm, i), 32'(in_ready), 32'(i != n - 1));
            chk($sformatf("%s err@%0d", nm, i), 32'(error), 32'd0);
            if (i != n - 1) begin
                int gaps = (gap_mode == 1) ? 1 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
                for (int g = 0; g < gaps; g++) begin
                    in_data = W'($urandom);
                    in_last = 1'($urandom);
                    step();
                    chk($sformatf("%s gap done", nm), 32'(sortdone), 32'd0);
                end
            end
        end
        in_last = 1'b0;
        check_outputs(nm, ev, ep, ecnt);
        step();
        chk($sformatf("%s done pulse width", nm), 32'(sortdone), 32'd0);
        chk($sformatf("%s ready in DONE", nm), 32'(in_ready), 32'd0);
        check_outputs($sformatf("%s hold", nm), ev, ep, ecnt);
    endtask

    task automatic feed(input logic [W-1:0] d, input logic last, input logic ss);
        in_valid  = 1'b1;
        in_data   = d;
        in_last   = last;
        sortstart = ss;
        step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        sortstart = 1'b0;
    endtask

    vec_t tbl [5];

    initial begin
        vals_t ev, d;
        poss_t ep;

        reset = 1'b0; sortstart = 1'b0; descending = 1'b0;
        in_valid = 1'b0; in_data = '0; in_last = 1'b0;

        tbl[0] = '{"asc5", 1'b0, 5, mkv(5,3,9,3,1,0,0,0), 1'b1,
                   mkv(1,3,3,5,9,0,0,0), mkp(4,1,3,0,2,8,8,8), 5};
        tbl[1] = '{"desc8", 1'b1, 8, mkv(10,11,12,13,14,15,16,17), 1'b0,
                   mkv(17,16,15,14,13,12,11,10), mkp(7,6,5,4,3,2,1,0), 8};
        tbl[2] = '{"single", 1'b0, 1, mkv(255,0,0,0,0,0,0,0), 1'b1,
                   mkv(255,0,0,0,0,0,0,0), mkp(0,8,8,8,8,8,8,8), 1};
        tbl[3] = '{"desc_ties", 1'b1, 5, mkv(4,7,4,7,2,0,0,0), 1'b1,
                   mkv(7,7,4,4,2,0,0,0), mkp(1,3,0,2,4,8,8,8), 5};
        tbl[4] = '{"asc_all_eq", 1'b0, 8, mkv(2,2,2,2,2,2,2,2), 1'b0,
                   mkv(2,2,2,2,2,2,2,2), mkp(0,1,2,3,4,5,6,7), 8};

        #12;
        chk("reset ready", 32'(in_ready), 32'd0);
        chk("reset done", 32'(sortdone), 32'd0);
        chk("reset error", 32'(error), 32'd0);
        check_outputs("reset", mkv(0,0,0,0,0,0,0,0), mkp(8,8,8,8,8,8,8,8), 0);
        reset = 1'b1;
        step();

        for (int t = 0; t < 5; t++)
            run_batch(tbl[t].name, tbl[t].desc, tbl[t].n, tbl[t].data, tbl[t].use_last, 0,
                      tbl[t].ev, tbl[t].ep, tbl[t].ecnt);

        run_batch("gapped", tbl[0].desc, tbl[0].n, tbl[0].data, 1'b1, 1, tbl[0].ev, tbl[0].ep, tbl[0].ecnt);

        // sortstart mid-batch and in_valid in DONE both flag error without disturbing the batch
        start_batch("proto", 1'b0);
        feed(8'd6, 1'b0, 1'b0);
        feed(8'd2, 1'b0, 1'b0);
        feed(8'd4, 1'b0, 1'b1);
        chk("proto err on sortstart", 32'(error), 32'd1);
        chk("proto ready kept", 32'(in_ready), 32'd1);
        feed(8'd1, 1'b1, 1'b0);
        chk("proto err cleared", 32'(error), 32'd0);
        chk("proto done", 32'(sortdone), 32'd1);
        feed(8'd0, 1'b0, 1'b0);
        chk("proto err in DONE", 32'(error), 32'd1);
        check_outputs("proto", mkv(1,2,4,6,0,0,0,0), mkp(3,1,2,0,8,8,8,8), 4);
        step();
        chk("proto err pulse width", 32'(error), 32'd0);

        // reset mid-batch: immediate return to reset contents
        start_batch("rst", 1'b1);
        feed(8'd9, 1'b0, 1'b0);
        feed(8'd3, 1'b0, 1'b0);
        feed(8'd7, 1'b0, 1'b0);
        chk("rst partial count", 32'(sorted_count), 32'd3);
        #3 reset = 1'b0;
        #1;
        chk("rst ready", 32'(in_ready), 32'd0);
        check_outputs("rst async", mkv(0,0,0,0,0,0,0,0), mkp(8,8,8,8,8,8,8,8), 0);
        #2 reset = 1'b1;
        step();
        run_batch("after_rst", tbl[0].desc, tbl[0].n, tbl[0].data, 1'b1, 0, tbl[0].ev, tbl[0].ep, tbl[0].ecnt);

        for (int b = 0; b < 200; b++) begin
            logic desc;
            logic use_last;
            int   n;
            bit   narrow;
            desc   = 1'($urandom);
            n      = int'($urandom_range(1, N));
            narrow = 1'($urandom);
            for (int i = 0; i < N; i++)
                d[i] = narrow ? W'($urandom_range(0, 5)) : W'($urandom);
            use_last = (n < N) ? 1'b1 : 1'($urandom);
            model(desc, n, d, ev, ep);
            run_batch($sformatf("rand%0d", b), desc, n, d, use_last, 2, ev, ep, n);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
